// File: rtl/version_reporter.sv
// version_reporter: streams one ASCII identification line built from the
// version_pkg constants over a byte-wide valid/ready interface.
// Line: "V<maj>.<min>.<patch>+<build> YYYY-MM-DD hh:mm:ss\r\n".
// Optional build macro VERSION_REPORTER_CHECKSUM_EN appends "*XX" before CR,
// where XX is the XOR of every byte from 'V' through the last seconds digit.

package version_pkg;
  localparam logic [7:0]  C_VERSION_MAJOR  = 8'd0;
  localparam logic [7:0]  C_VERSION_MINOR  = 8'd0;
  localparam logic [7:0]  C_VERSION_PATCH  = 8'd0;
  localparam logic [7:0]  C_VERSION_BUILD  = 8'd71;
  localparam logic [15:0] C_VERSION_YEAR   = 16'h2025;
  localparam logic [7:0]  C_VERSION_MONTH  = 8'h11;
  localparam logic [7:0]  C_VERSION_DAY    = 8'h11;
  localparam logic [7:0]  C_VERSION_HOUR   = 8'h11;
  localparam logic [7:0]  C_VERSION_MINUTE = 8'h30;
  localparam logic [7:0]  C_VERSION_SECOND = 8'h57;
endpackage

module version_reporter #(
  parameter logic [7:0]  P_MAJOR  = version_pkg::C_VERSION_MAJOR,
  parameter logic [7:0]  P_MINOR  = version_pkg::C_VERSION_MINOR,
  parameter logic [7:0]  P_PATCH  = version_pkg::C_VERSION_PATCH,
  parameter logic [7:0]  P_BUILD  = version_pkg::C_VERSION_BUILD,
  parameter logic [15:0] P_YEAR   = version_pkg::C_VERSION_YEAR,
  parameter logic [7:0]  P_MONTH  = version_pkg::C_VERSION_MONTH,
  parameter logic [7:0]  P_DAY    = version_pkg::C_VERSION_DAY,
  parameter logic [7:0]  P_HOUR   = version_pkg::C_VERSION_HOUR,
  parameter logic [7:0]  P_MINUTE = version_pkg::C_VERSION_MINUTE,
  parameter logic [7:0]  P_SECOND = version_pkg::C_VERSION_SECOND
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  output logic       busy,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Decimal digits of the four binary fields: [field][0=hundreds,1=tens,2=ones].
  typedef logic [3:0][2:0][3:0] digits_t;

  // Fixed slot map; slots 1..15 hold the binary fields (4 slots per field,
  // the fourth being its trailing separator). Suppressed zeros are skipped.
  localparam logic [5:0] SLOT_V = 6'd0;
`ifdef VERSION_REPORTER_CHECKSUM_EN
  localparam logic [5:0] SLOT_STAR  = 6'd36;
  localparam logic [5:0] SLOT_CK_HI = 6'd37;
  localparam logic [5:0] SLOT_CK_LO = 6'd38;
  localparam logic [5:0] SLOT_CR    = 6'd39;
  localparam logic [5:0] SLOT_LF    = 6'd40;
`else
  localparam logic [5:0] SLOT_CR    = 6'd36;
  localparam logic [5:0] SLOT_LF    = 6'd37;
`endif

  function automatic logic [11:0] to_dec(input logic [7:0] v);
    return {4'(v % 8'd10), 4'((v % 8'd100) / 8'd10), 4'(v / 8'd100)};
  endfunction

  function automatic logic [7:0] nib_char(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) c = 8'h30 + {4'h0, n};
    else           c = 8'h37 + {4'h0, n};
    return c;
  endfunction

  function automatic logic slot_ok(input logic [5:0] s, input digits_t d);
    logic [3:0] t;
    logic       ok;
    t = s[3:0] - 4'd1;
    ok = 1'b1;
    if ((s >= 6'd1) && (s <= 6'd15)) begin
      case (t[1:0])
        2'd0:    ok = (d[t[3:2]][0] != 4'd0);
        2'd1:    ok = (d[t[3:2]][0] != 4'd0) || (d[t[3:2]][1] != 4'd0);
        default: ok = 1'b1;
      endcase
    end else begin
      ok = 1'b1;
    end
    return ok;
  endfunction

  function automatic logic [5:0] next_slot(input logic [5:0] s, input digits_t d);
    logic [5:0] n;
    if (slot_ok(s + 6'd1, d))      n = s + 6'd1;
    else if (slot_ok(s + 6'd2, d)) n = s + 6'd2;
    else                           n = s + 6'd3;
    return n;
  endfunction

  function automatic logic [7:0] char_of(input logic [5:0] s, input digits_t d);
    logic [3:0] t;
    logic [7:0] c;
    t = s[3:0] - 4'd1;
    c = 8'h00;
    case (s)
      SLOT_V:        c = 8'h56;
      6'd4, 6'd8:    c = 8'h2E;
      6'd12:         c = 8'h2B;
      6'd16, 6'd27:  c = 8'h20;
      6'd17:         c = nib_char(P_YEAR[15:12]);
      6'd18:         c = nib_char(P_YEAR[11:8]);
      6'd19:         c = nib_char(P_YEAR[7:4]);
      6'd20:         c = nib_char(P_YEAR[3:0]);
      6'd21, 6'd24:  c = 8'h2D;
      6'd22:         c = nib_char(P_MONTH[7:4]);
      6'd23:         c = nib_char(P_MONTH[3:0]);
      6'd25:         c = nib_char(P_DAY[7:4]);
      6'd26:         c = nib_char(P_DAY[3:0]);
      6'd28:         c = nib_char(P_HOUR[7:4]);
      6'd29:         c = nib_char(P_HOUR[3:0]);
      6'd30, 6'd33:  c = 8'h3A;
      6'd31:         c = nib_char(P_MINUTE[7:4]);
      6'd32:         c = nib_char(P_MINUTE[3:0]);
      6'd34:         c = nib_char(P_SECOND[7:4]);
      6'd35:         c = nib_char(P_SECOND[3:0]);
`ifdef VERSION_REPORTER_CHECKSUM_EN
      SLOT_STAR:     c = 8'h2A;
`endif
      SLOT_CR:       c = 8'h0D;
      SLOT_LF:       c = 8'h0A;
      default: begin
        if ((s >= 6'd1) && (s <= 6'd15)) begin
          case (t[1:0])
            2'd0:    c = 8'h30 + {4'h0, d[t[3:2]][0]};
            2'd1:    c = 8'h30 + {4'h0, d[t[3:2]][1]};
            2'd2:    c = 8'h30 + {4'h0, d[t[3:2]][2]};
            default: c = 8'h00;
          endcase
        end else begin
          c = 8'h00;
        end
      end
    endcase
    return c;
  endfunction

  state_t     state_r, state_s;
  logic [5:0] slot_r, slot_s, nxt_s;
  digits_t    dig_r;
  logic [7:0] m_data_r, data_s;
  logic       m_valid_r, valid_s;
  logic       m_last_r, last_s;
  logic       busy_r, busy_s;
  logic       load_s;
`ifdef VERSION_REPORTER_CHECKSUM_EN
  logic [7:0] xor_r, xor_s;
`endif

  assign busy    = busy_r;
  assign m_data  = m_data_r;
  assign m_valid = m_valid_r;
  assign m_last  = m_last_r;

  // Next-state and next-output logic; the outputs themselves are registered.
  always_comb begin
    state_s = state_r;
    slot_s  = slot_r;
    data_s  = m_data_r;
    valid_s = m_valid_r;
    last_s  = m_last_r;
    busy_s  = busy_r;
    load_s  = 1'b0;
    nxt_s   = next_slot(slot_r, dig_r);
`ifdef VERSION_REPORTER_CHECKSUM_EN
    xor_s   = xor_r;
`endif
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (req) begin
          state_s = ST_LOAD;
          busy_s  = 1'b1;
`ifdef VERSION_REPORTER_CHECKSUM_EN
          xor_s   = 8'h00;
`endif
        end else begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
        end
      end
      ST_LOAD: begin
        load_s  = 1'b1;
        state_s = ST_EMIT;
        slot_s  = SLOT_V;
        data_s  = 8'h56;
        valid_s = 1'b1;
        last_s  = 1'b0;
        busy_s  = 1'b1;
      end
      ST_EMIT: begin
        if (m_valid_r && m_ready) begin
`ifdef VERSION_REPORTER_CHECKSUM_EN
          if (slot_r < SLOT_STAR) xor_s = xor_r ^ m_data_r;
          else                    xor_s = xor_r;
`endif
          if (m_last_r) begin
            state_s = ST_DONE;
            valid_s = 1'b0;
            last_s  = 1'b0;
            busy_s  = 1'b0;
            data_s  = 8'h00;
          end else begin
            slot_s  = nxt_s;
            data_s  = char_of(nxt_s, dig_r);
`ifdef VERSION_REPORTER_CHECKSUM_EN
            if (nxt_s == SLOT_CK_HI)      data_s = nib_char(xor_r[7:4]);
            else if (nxt_s == SLOT_CK_LO) data_s = nib_char(xor_r[3:0]);
            else                          data_s = char_of(nxt_s, dig_r);
`endif
            last_s  = (nxt_s == SLOT_LF);
          end
        end else begin
          state_s = ST_EMIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
        last_s  = 1'b0;
        busy_s  = 1'b0;
        data_s  = 8'h00;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Registered outputs, slot pointer, captured digits and running checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_r    <= 6'd0;
      dig_r     <= '0;
      m_data_r  <= 8'h00;
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
      busy_r    <= 1'b0;
`ifdef VERSION_REPORTER_CHECKSUM_EN
      xor_r     <= 8'h00;
`endif
    end else begin
      slot_r    <= slot_s;
      m_data_r  <= data_s;
      m_valid_r <= valid_s;
      m_last_r  <= last_s;
      busy_r    <= busy_s;
      if (load_s) dig_r <= {to_dec(P_BUILD), to_dec(P_PATCH), to_dec(P_MINOR), to_dec(P_MAJOR)};
      else        dig_r <= dig_r;
`ifdef VERSION_REPORTER_CHECKSUM_EN
      xor_r     <= xor_s;
`endif
    end
  end

endmodule

// File: tb/tb_version_reporter.sv
// Directed bench for version_reporter: default and overridden instances,
// back-to-back and stalled streaming, ignored requests, mid-line reset.
module tb_version_reporter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_v, ready_v, sel;
  logic       req_a, req_b, ready_a, ready_b;
  logic       busy_a, valid_a, last_a, busy_b, valid_b, last_b;
  logic [7:0] data_a, data_b;
  logic       busy_m, valid_m, last_m;
  logic [7:0] data_m;
  int         tests = 0;
  int         fails = 0;
  string      line_a, line_b;

  always #5 clk = ~clk;

  assign req_a   = req_v & ~sel;
  assign req_b   = req_v & sel;
  assign ready_a = ready_v & ~sel;
  assign ready_b = ready_v & sel;
  assign busy_m  = sel ? busy_b  : busy_a;
  assign valid_m = sel ? valid_b : valid_a;
  assign last_m  = sel ? last_b  : last_a;
  assign data_m  = sel ? data_b  : data_a;

  version_reporter dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .busy(busy_a),
    .m_data(data_a), .m_valid(valid_a), .m_ready(ready_a), .m_last(last_a)
  );

  version_reporter #(.P_MAJOR(8'd255), .P_BUILD(8'd0), .P_MONTH(8'h1A)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .busy(busy_b),
    .m_data(data_b), .m_valid(valid_b), .m_ready(ready_b), .m_last(last_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_line(input bit rnd, input int dup_at, input int abort_at,
                          input bit req_on_lf, input string exp, input string tag);
    int         idx;
    int         cycles;
    bit         done;
    bit         stall;
    logic [7:0] hold_data;
    logic       hold_last;
    logic       rdy;
    idx = 0; cycles = 0; done = 1'b0; stall = 1'b0;
    hold_data = 8'h00; hold_last = 1'b0;
    @(negedge clk); req_v = 1'b1; ready_v = 1'b0;
    @(negedge clk); req_v = 1'b0;
    check({tag, "_busy_rise"}, 32'(busy_m), 32'd1);
    check({tag, "_load_no_valid"}, 32'(valid_m), 32'd0);
    @(negedge clk);
    check({tag, "_first_valid"}, 32'(valid_m), 32'd1);
    while (!done && cycles < 400) begin
      if (cycles > 0) @(negedge clk);
      cycles++;
      req_v = 1'b0;
      if (stall) begin
        check({tag, $sformatf("_stall_valid%0d", idx)}, 32'(valid_m), 32'd1);
        check({tag, $sformatf("_stall_data%0d", idx)}, 32'(data_m), 32'(hold_data));
        check({tag, $sformatf("_stall_last%0d", idx)}, 32'(last_m), 32'(hold_last));
      end
      if (abort_at >= 0 && idx == abort_at && valid_m) begin
        #1 rst_n = 1'b0;
        #1;
        check({tag, "_rst_valid"}, 32'(valid_m), 32'd0);
        check({tag, "_rst_busy"}, 32'(busy_m), 32'd0);
        check({tag, "_rst_data"}, 32'(data_m), 32'd0);
        check({tag, "_rst_last"}, 32'(last_m), 32'd0);
        @(negedge clk); rst_n = 1'b1; ready_v = 1'b1;
        repeat (4) @(negedge clk);
        check({tag, "_norestart_valid"}, 32'(valid_m), 32'd0);
        check({tag, "_norestart_busy"}, 32'(busy_m), 32'd0);
        ready_v = 1'b0;
        return;
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid_m) begin
        if (rdy) begin
          check({tag, $sformatf("_byte%0d", idx)}, 32'(data_m), 32'(exp[idx]));
          check({tag, $sformatf("_last%0d", idx)}, 32'(last_m), 32'(idx == exp.len() - 1));
          if (req_on_lf && last_m) req_v = 1'b1;
          idx++;
          done  = last_m || (idx >= exp.len());
          stall = 1'b0;
        end else begin
          stall     = 1'b1;
          hold_data = data_m;
          hold_last = last_m;
        end
      end else begin
        stall = 1'b0;
      end
      if (dup_at >= 0 && idx == dup_at && valid_m) req_v = 1'b1;
      ready_v = rdy;
    end
    check({tag, "_complete"}, 32'(done), 32'd1);
    check({tag, "_count"}, 32'(idx), 32'(exp.len()));
    if (!rnd) check({tag, "_back_to_back"}, 32'(cycles), 32'(exp.len()));
    @(negedge clk); req_v = 1'b0; ready_v = 1'b0;
    check({tag, "_busy_fall"}, 32'(busy_m), 32'd0);
    check({tag, "_valid_off"}, 32'(valid_m), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_no_requeue_busy"}, 32'(busy_m), 32'd0);
    check({tag, "_no_requeue_valid"}, 32'(valid_m), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_v = 1'b0; ready_v = 1'b0; sel = 1'b0;
`ifdef VERSION_REPORTER_CHECKSUM_EN
    line_a = "V0.0.0+71 2025-11-11 11:30:57*4F\r\n";
    line_b = "V255.0.0+0 2025-1A-11 11:30:57*0B\r\n";
`else
    line_a = "V0.0.0+71 2025-11-11 11:30:57\r\n";
    line_b = "V255.0.0+0 2025-1A-11 11:30:57\r\n";
`endif
    repeat (2) @(negedge clk);
    check("reset_busy_a", 32'(busy_a), 32'd0);
    check("reset_valid_a", 32'(valid_a), 32'd0);
    check("reset_last_a", 32'(last_a), 32'd0);
    check("reset_data_a", 32'(data_a), 32'd0);
    check("reset_valid_b", 32'(valid_b), 32'd0);
    check("reset_busy_b", 32'(busy_b), 32'd0);
    rst_n = 1'b1;
    ready_v = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready_valid", 32'(valid_m), 32'd0);
    check("idle_ready_busy", 32'(busy_m), 32'd0);
    ready_v = 1'b0;

    run_line(1'b0, -1, -1, 1'b1, line_a, "b2b");
    run_line(1'b1, -1, -1, 1'b0, line_a, "rnd");
    run_line(1'b0, 10, -1, 1'b0, line_a, "dup");
    run_line(1'b0, -1, -1, 1'b0, line_a, "again");
    sel = 1'b1;
    run_line(1'b1, -1, -1, 1'b0, line_b, "ovr");
    sel = 1'b0;
    run_line(1'b0, -1, 15, 1'b0, line_a, "abort");
    run_line(1'b0, -1, -1, 1'b0, line_a, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/version_reporter.md
Name: version_reporter

Overview:
- On request, serializes the build's version and timestamp constants as one ASCII text line over a byte stream with a valid/ready handshake.
- Acts as the reader and consumer of the auto-updated version package, so host software (UART bridge, debug FIFO) can identify the bitstream.
- Sits between the version package and any byte-wide transmit path.

Parameters:
- P_MAJOR, version_pkg::C_VERSION_MAJOR, 8-bit binary major version.
- P_MINOR, version_pkg::C_VERSION_MINOR, 8-bit binary minor version.
- P_PATCH, version_pkg::C_VERSION_PATCH, 8-bit binary patch number.
- P_BUILD, version_pkg::C_VERSION_BUILD, 8-bit binary build number.
- P_YEAR, version_pkg::C_VERSION_YEAR, 16-bit BCD year.
- P_MONTH / P_DAY / P_HOUR / P_MINUTE / P_SECOND, matching version_pkg constants, 8-bit BCD each.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  single-cycle start pulse.
- busy  out  1  high from accepted req until the final byte handshakes.
- m_data  out  8  ASCII byte.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  downstream accepts the byte.
- m_last  out  1  high with the final byte (LF).

Behaviour:
- Reset, asynchronous and active-low: busy=0, m_valid=0, m_last=0, m_data=8'h00, FSM=IDLE.
- Line format: "V" maj "." min "." patch "+" build " " YYYY "-" MM "-" DD " " hh ":" mm ":" ss CR LF.
- Binary fields print in decimal with leading zeros suppressed (0→"0", 7→"7", 71→"71", 255→"255").
- BCD fields print as exactly 2 characters (4 for year), one per nibble. Nibble 0-9 → '0'-'9'; nibble A-F → 'A'-'F' (no error).
- FSM states:
  - IDLE: req=1 → LOAD. busy rises the cycle after req.
  - LOAD: computes hundreds/tens/ones digits of the current binary field (registered, 1 cycle) → EMIT.
  - EMIT: steps through the field and separator characters, one byte per handshake.
  - DONE: after the LF handshake → IDLE; busy falls the same cycle.
- Latency: first m_valid exactly 2 cycles after the req cycle.
- Handshake:
  - A byte transfers on a clock edge where m_valid && m_ready.
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable.
  - m_valid never drops without a transfer.
  - After a transfer, the next byte may be valid the very next cycle, so full throughput is 1 byte/cycle when m_ready is held high.
- req while busy=1: ignored; no queuing.
- req in the same cycle as the LF transfer: ignored.
- m_ready high while m_valid=0: no effect.
- rst_n asserted mid-line: outputs return to reset values immediately (asynchronous). After release, no partial-line resume; the next req starts again at "V".
- Default line "V0.0.0+71 2025-11-11 11:30:57\r\n" = 31 bytes.

Optional Feature:
- Macro: VERSION_REPORTER_CHECKSUM_EN.
- When defined:
  - Before CR, emits '*' followed by 2 uppercase hex digits.
  - The digits are the XOR of every byte from 'V' through the last seconds digit inclusive.
  - Running XOR register resets on each accepted req.
  - Default line becomes "...11:30:57*4F\r\n" = 34 bytes.
- When undefined: no '*', no checksum register, 31-byte line.

Test Plan:
- Reset then req, m_ready tied 1 → bytes 0x56,0x30,0x2E,... ending 0x0D,0x0A. Exactly 31 valid cycles, back-to-back. m_last only on 0x0A. busy low the cycle after the LF.
- m_ready random ~50% → identical 31-byte sequence. m_data stable throughout every stall. No dropped or duplicated bytes.
- Second req pulse at byte 10 while busy → ignored. Exactly one 31-byte line. A fresh req after busy=0 produces a second identical line.
- Override parameters P_MAJOR=255, P_BUILD=0, P_MONTH=8'h1A → line starts "V255.0.0+0 " and month prints "1A".
- rst_n pulsed low during byte 15 → m_valid=0 and busy=0 asynchronously. After release with no req: m_valid stays 0. Next req produces a full line from 'V'.
- VERSION_REPORTER_CHECKSUM_EN defined, defaults → 34 bytes. Bytes 29-31 are 0x2A,0x34,0x46 ("*4F"), followed by 0x0D,0x0A with m_last on 0x0A.
